// File: rtl/fp8_e4m3_subtractor_seq.sv
// Multi-cycle FP8 E4M3 subtractor: diff = a - b.
// Operands are expanded serially into 2^-9 fixed point, subtracted in one
// cycle, then the magnitude is normalized serially in the register that held
// the minuend, and rounded to nearest-even with saturation at +/-448.
module fp8_e4m3_subtractor_seq #(
  parameter logic [7:0] NAN_VALUE = 8'h7F,
  parameter logic [6:0] SAT_MAG   = 7'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] diff,
  output logic       out_nan,
  output logic       out_sat
);

  // 448 * 2^9: smallest magnitude that no longer fits below the saturation code
  localparam logic [18:0] SAT_THRESH = 19'd229376;

  typedef enum logic [2:0] {IDLE, EXPAND, SUB, NORM, ROUND, DONE} state_t;

  state_t      state, state_nxt;

  logic [18:0] acc;        // expanded |a| during EXPAND, |a - b| from SUB onwards
  logic [17:0] opb;        // expanded |b|
  logic [3:0]  cnt_a, cnt_b;
  logic        sign_a, sign_b, res_sign;
  logic [3:0]  exp_r;
  logic        sat_pend, zero_pend;
  logic [7:0]  diff_q;
  logic        nan_q, sat_q, valid_q;

  logic        a_nan, b_nan, accept, expand_done;
  logic        sat_hit, zero_hit, norm_hold, norm_exit, out_fire;

  assign a_nan       = (a[6:0] == 7'h7F);
  assign b_nan       = (b[6:0] == 7'h7F);
  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  // Both counts reach zero with this cycle's shift, so EXPAND never idles a cycle
  assign expand_done = (cnt_a <= 4'd1) && (cnt_b <= 4'd1);
  // Saturation is only judged before any normalization shift (E still 15)
  assign sat_hit     = (exp_r == 4'd15) && (acc >= SAT_THRESH);
  assign zero_hit    = (acc == 19'd0);
  // No shift is needed at all this cycle
  assign norm_hold   = sat_hit || zero_hit || acc[17] || (exp_r == 4'd1);
  // Leave once the shift taken this cycle lands the leading one or reaches E=1
  assign norm_exit   = norm_hold || acc[16] || (exp_r == 4'd2);
  assign out_fire    = valid_q && out_ready;

  assign out_valid = valid_q;
  assign diff      = diff_q;
  assign out_nan   = nan_q;
  assign out_sat   = sat_q;

  // Signed subtraction of the expanded operands (b's sign already inverted)
  logic [19:0] op_a_s, op_b_s, d_sum, d_neg;
  logic [18:0] d_mag;
  assign op_a_s = sign_a ? (20'd0 - {2'b00, acc[17:0]}) : {2'b00, acc[17:0]};
  assign op_b_s = sign_b ? (20'd0 - {2'b00, opb})       : {2'b00, opb};
  assign d_sum  = op_a_s + op_b_s;
  assign d_neg  = 20'd0 - d_sum;
  assign d_mag  = d_sum[19] ? d_neg[18:0] : d_sum[18:0];

  // Field extraction and round-to-nearest-even of the normalized magnitude
  logic [3:0] exp_f;
  logic       rnd_up, ovf;
  logic [7:0] rsum;
  assign exp_f  = acc[17] ? exp_r : 4'd0;
  assign rnd_up = acc[13] && ((|acc[12:0]) || acc[14]);
  // A mantissa carry ripples straight into the exponent field
  assign rsum   = {1'b0, exp_f, acc[16:14]} + {7'd0, rnd_up};
  assign ovf    = rsum[7] || (rsum[6:0] == 7'h7F);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: a default on every path keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (a_nan || b_nan) ? DONE : EXPAND;
      EXPAND:  if (expand_done) state_nxt = SUB;
      SUB:     state_nxt = NORM;
      NORM:    if (norm_exit) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset (no RAM in this block) so that an
    // aborted operation leaves nothing behind for the next one.
    if (rst) begin
      acc       <= '0;
      opb       <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      res_sign  <= 1'b0;
      exp_r     <= '0;
      sat_pend  <= 1'b0;
      zero_pend <= 1'b0;
      diff_q    <= 8'h00;
      nan_q     <= 1'b0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (accept) begin
            sat_q  <= 1'b0;
            sign_a <= a[7];
            sign_b <= ~b[7];
            acc    <= {15'd0, (a[6:3] != 4'd0), a[2:0]};
            opb    <= {14'd0, (b[6:3] != 4'd0), b[2:0]};
            cnt_a  <= (a[6:3] == 4'd0) ? 4'd0 : a[6:3] - 4'd1;
            cnt_b  <= (b[6:3] == 4'd0) ? 4'd0 : b[6:3] - 4'd1;
            if (a_nan || b_nan) begin
              diff_q <= NAN_VALUE;
              nan_q  <= 1'b1;
            end else begin
              nan_q  <= 1'b0;
            end
          end
        end
        EXPAND: begin
          if (cnt_a != 4'd0) begin
            acc   <= acc << 1;
            cnt_a <= cnt_a - 4'd1;
          end
          if (cnt_b != 4'd0) begin
            opb   <= opb << 1;
            cnt_b <= cnt_b - 4'd1;
          end
        end
        SUB: begin
          res_sign <= d_sum[19];
          acc      <= d_mag;
          exp_r    <= 4'd15;
        end
        NORM: begin
          sat_pend  <= sat_hit;
          zero_pend <= zero_hit;
          if (!norm_hold) begin
            acc   <= acc << 1;
            exp_r <= exp_r - 4'd1;
          end
        end
        ROUND: begin
          if (zero_pend) begin
            diff_q <= 8'h00;
            sat_q  <= 1'b0;
          end else if (sat_pend || ovf) begin
            diff_q <= {res_sign, SAT_MAG};
            sat_q  <= 1'b1;
          end else begin
            diff_q <= {res_sign, rsum[6:0]};
            sat_q  <= 1'b0;
          end
        end
        DONE: begin
          if (!valid_q)      valid_q <= 1'b1;
          else if (out_ready) valid_q <= 1'b0;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_e4m3_subtractor_seq.sv
// Directed bench for the sequential E4M3 subtractor: a vector table of
// hand-computed results plus backpressure and mid-operation reset sequences.
module tb_fp8_e4m3_subtractor_seq;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic       in_ready, out_valid, out_nan, out_sat;
  logic [7:0] a, b, diff;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       nan;
    logic       sat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  fp8_e4m3_subtractor_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .out_nan   (out_nan),
    .out_sat   (out_sat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // E4M3 value in units of 2^-9
  function automatic int val_of(input logic [7:0] x);
    int m;
    if (x[6:3] == 4'd0) m = int'(x[2:0]);
    else                m = int'({1'b1, x[2:0]}) << (int'(x[6:3]) - 1);
    return x[7] ? -m : m;
  endfunction

  // Accept edge to out_valid: EXPAND + SUB + NORM + ROUND + DONE entry
  function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
    int ca, cb, ex, m, e, sh;
    if (x[6:0] == 7'h7F || y[6:0] == 7'h7F) return 1;
    ca = (x[6:3] == 4'd0) ? 0 : int'(x[6:3]) - 1;
    cb = (y[6:3] == 4'd0) ? 0 : int'(y[6:3]) - 1;
    ex = (ca > cb) ? ca : cb;
    if (ex < 1) ex = 1;
    m = val_of(x) - val_of(y);
    if (m < 0) m = -m;
    sh = 0;
    e  = 15;
    if (m != 0 && m < 229376) begin
      while (m[17] == 1'b0 && e > 1) begin
        m = m << 1;
        e--;
        sh++;
      end
    end
    if (sh < 1) sh = 1;
    return ex + 1 + sh + 1 + 1;
  endfunction

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 1'b0);
    check({tag, " in_ready after handshake"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] vd, input logic vn, input logic vs);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1'b1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready after accept"}, in_ready, 1'b0);
    check({tag, " out_sat cleared on accept"}, out_sat, 1'b0);
    wait_valid(cyc);
    check({tag, " latency"}, cyc, lat_of(va, vb));
    check({tag, " diff"}, diff, vd);
    check({tag, " out_nan"}, out_nan, vn);
    check({tag, " out_sat"}, out_sat, vs);
    handshake(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    vecs[0]  = '{8'h40, 8'h38, 8'h38, 1'b0, 1'b0};  // 2.0 - 1.0
    vecs[1]  = '{8'h38, 8'h98, 8'h38, 1'b0, 1'b0};  // 1.0625, tie to even
    vecs[2]  = '{8'h39, 8'h98, 8'h3A, 1'b0, 1'b0};  // 1.1875, tie rounds up
    vecs[3]  = '{8'h7E, 8'hFE, 8'h7E, 1'b0, 1'b1};  // 896 saturates
    vecs[4]  = '{8'h7F, 8'h38, 8'h7F, 1'b1, 1'b0};  // NaN minuend
    vecs[5]  = '{8'h38, 8'hFF, 8'h7F, 1'b1, 1'b0};  // NaN subtrahend
    vecs[6]  = '{8'h02, 8'h01, 8'h01, 1'b0, 1'b0};  // subnormal
    vecs[7]  = '{8'h38, 8'h38, 8'h00, 1'b0, 1'b0};  // exact zero
    vecs[8]  = '{8'h80, 8'h00, 8'h00, 1'b0, 1'b0};  // -0 - 0 gives +0
    vecs[9]  = '{8'h01, 8'h08, 8'h87, 1'b0, 1'b0};  // 2^-9 - 2^-6 = -7*2^-9
    vecs[10] = '{8'h01, 8'h09, 8'h88, 1'b0, 1'b0};  // 1 - 9 = -8 units = -2^-6
    vecs[11] = '{8'h38, 8'h40, 8'hB8, 1'b0, 1'b0};  // 1.0 - 2.0
    vecs[12] = '{8'h77, 8'h70, 8'h6E, 1'b0, 1'b0};  // 240 - 128 = 112
    vecs[13] = '{8'hFE, 8'h7E, 8'hFE, 1'b0, 1'b1};  // -896 saturates negative

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset diff", diff, 8'h00);
    check("reset out_nan", out_nan, 1'b0);
    check("reset out_sat", out_sat, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].nan, vecs[i].sat);

    // Backpressure: result held while new operands wait at the input
    a = 8'h39;
    b = 8'h98;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h38;
    b = 8'hB8;
    wait_valid(cyc);
    check("bp first latency", cyc, lat_of(8'h39, 8'h98));
    check("bp first diff", diff, 8'h3A);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold diff", diff, 8'h3A);
      check("bp hold in_ready", in_ready, 1'b0);
      check("bp hold out_valid", out_valid, 1'b1);
    end
    handshake("bp first");
    @(posedge clk); #1;
    check("bp queued accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp queued latency", cyc, lat_of(8'h38, 8'hB8));
    check("bp queued diff", diff, 8'h40);
    check("bp queued out_sat", out_sat, 1'b0);
    handshake("bp queued");

    // Reset while normalizing 0x77 - 0x70 (EXPAND 13, SUB 1, then NORM)
    a = 8'h77;
    b = 8'h70;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      check("rst run out_valid", out_valid, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst diff", diff, 8'h00);
    check("midrst out_nan", out_nan, 1'b0);
    check("midrst out_sat", out_sat, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst in_ready after release", in_ready, 1'b1);
    check("midrst no late result", out_valid, 1'b0);
    run_op("after reset", 8'h77, 8'h70, 8'h6E, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
